// File: rtl/pcm56_load_scheduler_if.sv
// Sample-in / DAC-out signal bundle for pcm56_load_scheduler.
// The master drives samples and mute; the slave (scheduler) drives the DAC pins and status.
interface pcm56_load_scheduler_if;
  logic               l_stb_i;
  logic signed [23:0] l_data_i;
  logic               r_stb_i;
  logic signed [23:0] r_data_i;
  logic               mute_i;
  logic [3:0]         sdo_o;
  logic [3:0]         le_o;
  logic               busy_o;
  logic               ovf_o;

  modport master (
    output l_stb_i, l_data_i, r_stb_i, r_data_i, mute_i,
    input  sdo_o, le_o, busy_o, ovf_o
  );

  modport slave (
    input  l_stb_i, l_data_i, r_stb_i, r_data_i, mute_i,
    output sdo_o, le_o, busy_o, ovf_o
  );
endinterface

// File: rtl/pcm56_load_scheduler.sv
// Serialises left/right samples into four PCM56-style DACs, one channel pair at a time.
// Optional macro PCM56_ROUND_SAT_EN: round-to-nearest with saturation instead of truncation.
module pcm56_load_scheduler #(
  parameter int BITS      = 16,
  parameter int LATCH_LEN = 2
) (
  input  logic                   bck_i,
  input  logic                   rst_i,
  pcm56_load_scheduler_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, SHIFT, LATCH} state_t;

  localparam int CNT_W = $clog2(BITS > LATCH_LEN ? BITS : LATCH_LEN) + 1;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic signed [23:0] l_hold_p0, r_hold_p0;
  logic               l_pend, r_pend;
  logic               sel_r;      // channel in flight, or last served while idle (1 = right)
  logic               sel_nxt;
  logic               load;
  logic               ovf;
  logic [BITS-1:0]    shreg_p1;
  logic               sdo_bit;

  function automatic logic [BITS-1:0] to_word(input logic signed [23:0] s);
`ifdef PCM56_ROUND_SAT_EN
    localparam logic signed [24:0] HALF = 25'sd1 <<< (23 - BITS);
    logic signed [24:0] sum;
    logic        [23:0] sat;
    sum = $signed({s[23], s}) + HALF;
    // Adding a positive half-LSB can only overflow towards +full-scale.
    if (sum[24:23] == 2'b01) sat = 24'h7FFFFF;
    else                     sat = sum[23:0];
    return sat[23 -: BITS];
`else
    return s[23 -: BITS];
`endif
  endfunction

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    sel_nxt   = sel_r;
    case (state)
      IDLE: begin
        if (l_pend || r_pend) begin
          state_nxt = SHIFT;
          load      = 1'b1;
          sel_nxt   = (l_pend && r_pend) ? ~sel_r : r_pend;
        end
      end
      SHIFT:   if (cnt == CNT_W'(BITS - 1))      state_nxt = LATCH;
      LATCH:   if (cnt == CNT_W'(LATCH_LEN - 1)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    sdo_bit    = shreg_p1[BITS-1];
    bus.sdo_o  = 4'b0000;
    bus.le_o   = 4'b1111;
    if (state == SHIFT)
      bus.sdo_o = sel_r ? {sdo_bit, 1'b0, sdo_bit, 1'b0} : {1'b0, sdo_bit, 1'b0, sdo_bit};
    if (state == LATCH)
      bus.le_o  = sel_r ? 4'b0101 : 4'b1010;
    bus.busy_o = (state != IDLE);
    bus.ovf_o  = ovf;
  end

  always_ff @(posedge bck_i) begin
    if (rst_i) begin
      state     <= IDLE;
      cnt       <= '0;
      l_pend    <= 1'b0;
      r_pend    <= 1'b0;
      l_hold_p0 <= '0;
      r_hold_p0 <= '0;
      shreg_p1  <= '0;
      sel_r     <= 1'b1;
      ovf       <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= (state == IDLE || state_nxt != state) ? '0 : cnt + CNT_W'(1);

      // Stage p0: holding registers and pending flags
      if (bus.l_stb_i) l_hold_p0 <= bus.l_data_i;
      if (bus.r_stb_i) r_hold_p0 <= bus.r_data_i;
      if (bus.l_stb_i)              l_pend <= 1'b1;
      else if (load && !sel_nxt)    l_pend <= 1'b0;
      if (bus.r_stb_i)              r_pend <= 1'b1;
      else if (load && sel_nxt)     r_pend <= 1'b0;
      // A refill of the channel being consumed right now is not an overrun.
      if ((bus.l_stb_i && l_pend && !(load && !sel_nxt)) ||
          (bus.r_stb_i && r_pend && !(load &&  sel_nxt)))
        ovf <= 1'b1;

      // Stage p1: word shifter
      if (load) begin
        shreg_p1 <= bus.mute_i ? '0 : to_word(sel_nxt ? r_hold_p0 : l_hold_p0);
        sel_r    <= sel_nxt;
      end else if (state == SHIFT) begin
        shreg_p1 <= shreg_p1 << 1;
      end
    end
  end

endmodule

// File: tb/tb_pcm56_load_scheduler.sv
// Directed self-checking bench for pcm56_load_scheduler (default BITS=16, LATCH_LEN=2).
module tb_pcm56_load_scheduler;
  localparam int BITS = 16;
  localparam int LL   = 2;

  logic bck = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   passed = 0;

  pcm56_load_scheduler_if bus();

  pcm56_load_scheduler #(.BITS(BITS), .LATCH_LEN(LL)) dut (
    .bck_i (bck),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 bck = ~bck;

  typedef struct {
    logic [23:0] data;
    bit          is_r;
    bit          mute;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h", nm, act, exp);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge bck);
    rst = 1'b0;
  endtask

  // Waits for SHIFT, captures the serial word, then checks LATCH and return to IDLE.
  task automatic observe_load(input string nm, input bit is_r, input logic [15:0] exp,
                              output int waited);
    int          n = 0;
    logic [15:0] w = '0;
    logic        b;
    bit          sdo_bad = 0, le_bad = 0, lat_bad = 0;
    do begin
      @(negedge bck);
      n++;
    end while (!bus.busy_o && n < 100);
    waited = n;
    if (!bus.busy_o) begin
      check({nm, " start"}, 32'(bus.busy_o), 32'd1);
      return;
    end
    for (int k = 0; k < BITS; k++) begin
      if (k > 0) @(negedge bck);
      b = is_r ? bus.sdo_o[1] : bus.sdo_o[0];
      if (bus.sdo_o !== (is_r ? {b, 1'b0, b, 1'b0} : {1'b0, b, 1'b0, b})) sdo_bad = 1;
      if (bus.le_o !== 4'b1111 || bus.busy_o !== 1'b1) le_bad = 1;
      w = {w[14:0], b};
    end
    check({nm, " word"}, 32'(w), 32'(exp));
    check({nm, " sdo pairs"}, 32'(sdo_bad), 32'd0);
    check({nm, " le during shift"}, 32'(le_bad), 32'd0);
    for (int k = 0; k < LL; k++) begin
      @(negedge bck);
      if (bus.le_o !== (is_r ? 4'b0101 : 4'b1010) || bus.sdo_o !== 4'b0000 || bus.busy_o !== 1'b1)
        lat_bad = 1;
    end
    check({nm, " latch"}, 32'(lat_bad), 32'd0);
    @(negedge bck);
    check({nm, " idle after"}, {27'd0, bus.busy_o, bus.le_o}, {27'd0, 1'b0, 4'b1111});
  endtask

  initial begin
    int waited;
    bit bad;

    vecs[0] = '{24'h123456, 1'b0, 1'b0, 16'h1234};
`ifdef PCM56_ROUND_SAT_EN
    vecs[1] = '{24'h89ABCD, 1'b1, 1'b0, 16'h89AC};
    vecs[3] = '{24'h1234C0, 1'b0, 1'b0, 16'h1235};
    vecs[6] = '{24'hFFFFFF, 1'b1, 1'b0, 16'h0000};
`else
    vecs[1] = '{24'h89ABCD, 1'b1, 1'b0, 16'h89AB};
    vecs[3] = '{24'h1234C0, 1'b0, 1'b0, 16'h1234};
    vecs[6] = '{24'hFFFFFF, 1'b1, 1'b0, 16'hFFFF};
`endif
    vecs[2] = '{24'h7FFFFF, 1'b0, 1'b1, 16'h0000};
    vecs[4] = '{24'h7FFFFF, 1'b1, 1'b0, 16'h7FFF};
    vecs[5] = '{24'h800000, 1'b0, 1'b0, 16'h8000};

    bus.l_stb_i = 0; bus.r_stb_i = 0; bus.mute_i = 0;
    bus.l_data_i = '0; bus.r_data_i = '0;

    repeat (3) @(negedge bck);
    check("reset le", 32'(bus.le_o), 32'hF);
    check("reset sdo", 32'(bus.sdo_o), 32'h0);
    check("reset busy", 32'(bus.busy_o), 32'h0);
    check("reset ovf", 32'(bus.ovf_o), 32'h0);
    rst = 1'b0;

    // Single-channel loads with exact latency
    for (int i = 0; i < 7; i++) begin
      @(negedge bck);
      bus.mute_i = vecs[i].mute;
      if (vecs[i].is_r) begin bus.r_stb_i = 1; bus.r_data_i = vecs[i].data; end
      else              begin bus.l_stb_i = 1; bus.l_data_i = vecs[i].data; end
      @(negedge bck);
      bus.l_stb_i = 0; bus.r_stb_i = 0;
      check($sformatf("vec%0d load cycle busy", i), 32'(bus.busy_o), 32'd0);
      observe_load($sformatf("vec%0d", i), vecs[i].is_r, vecs[i].exp, waited);
      check($sformatf("vec%0d latency", i), 32'(waited), 32'd1);
      bus.mute_i = 0;
    end
    check("no ovf on singles", 32'(bus.ovf_o), 32'd0);

    // Simultaneous pairs: left first after reset, then round-robin
    do_reset();
    @(negedge bck);
    bus.l_stb_i = 1; bus.l_data_i = 24'hA5C300;
    bus.r_stb_i = 1; bus.r_data_i = 24'h3C5A00;
    @(negedge bck);
    bus.l_stb_i = 0; bus.r_stb_i = 0;
    observe_load("pair1 left", 1'b0, 16'hA5C3, waited);
    observe_load("pair1 right", 1'b1, 16'h3C5A, waited);
    check("pair1 right gap", 32'(waited), 32'd1);
    bus.l_stb_i = 1; bus.l_data_i = 24'h0F0F00;
    @(negedge bck);
    bus.l_stb_i = 0;
    observe_load("solo left", 1'b0, 16'h0F0F, waited);
    bus.l_stb_i = 1; bus.l_data_i = 24'h55AA00;
    bus.r_stb_i = 1; bus.r_data_i = 24'hC3A500;
    @(negedge bck);
    bus.l_stb_i = 0; bus.r_stb_i = 0;
    observe_load("pair2 right", 1'b1, 16'hC3A5, waited);
    observe_load("pair2 left", 1'b0, 16'h55AA, waited);
    check("pairs ovf", 32'(bus.ovf_o), 32'd0);

    // Two left strobes during one right load
    do_reset();
    check("ovf cleared by reset", 32'(bus.ovf_o), 32'd0);
    bus.r_stb_i = 1; bus.r_data_i = 24'h00FF00;
    @(negedge bck);
    bus.r_stb_i = 0;
    fork
      observe_load("ovr right", 1'b1, 16'h00FF, waited);
      begin
        repeat (4) @(negedge bck);
        bus.l_stb_i = 1; bus.l_data_i = 24'h111100;
        @(negedge bck);
        bus.l_stb_i = 0;
        check("ovf after first left", 32'(bus.ovf_o), 32'd0);
        repeat (3) @(negedge bck);
        bus.l_stb_i = 1; bus.l_data_i = 24'h222200;
        @(negedge bck);
        bus.l_stb_i = 0;
        check("ovf after second left", 32'(bus.ovf_o), 32'd1);
      end
    join
    observe_load("ovr left", 1'b0, 16'h2222, waited);
    check("ovf sticky", 32'(bus.ovf_o), 32'd1);

    // Refill of the selected channel in its own load cycle
    do_reset();
    bus.l_stb_i = 1; bus.l_data_i = 24'h0A0B00;
    @(negedge bck);
    bus.l_data_i = 24'h0C0D00;
    fork
      observe_load("refill old", 1'b0, 16'h0A0B, waited);
      begin @(negedge bck); bus.l_stb_i = 0; end
    join
    check("refill no ovf", 32'(bus.ovf_o), 32'd0);
    observe_load("refill new", 1'b0, 16'h0C0D, waited);

    // Reset at SHIFT bit 5 with a right sample pending
    do_reset();
    bus.l_stb_i = 1; bus.l_data_i = 24'h123456;
    @(negedge bck);
    bus.l_stb_i = 0;
    @(negedge bck);
    @(negedge bck);
    bus.r_stb_i = 1; bus.r_data_i = 24'h777700;
    @(negedge bck);
    bus.r_stb_i = 0;
    repeat (2) @(negedge bck);
    check("busy before abort", 32'(bus.busy_o), 32'd1);
    rst = 1'b1;
    @(negedge bck);
    rst = 1'b0;
    check("abort state", {23'd0, bus.busy_o, bus.le_o, bus.sdo_o}, {23'd0, 1'b0, 4'b1111, 4'b0000});
    bad = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge bck);
      if (bus.busy_o !== 1'b0 || bus.le_o !== 4'b1111 || bus.sdo_o !== 4'b0000) bad = 1;
    end
    check("no load after abort", 32'(bad), 32'd0);
    check("abort ovf", 32'(bus.ovf_o), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/pcm56_load_scheduler.md
PCM56_LOAD_SCHEDULER -- requirements
Module: pcm56_load_scheduler

Interface
REQ-001 The block SHALL have parameter BITS, default 16, giving the DAC word length shifted per load.
REQ-002 The block SHALL have parameter LATCH_LEN, default 2, giving the number of cycles LE is held low per load.
REQ-003 The block SHALL have port bck_i, input, width 1: the sole clock; all logic is on its rising edge.
REQ-004 The block SHALL have port rst_i, input, width 1: reset, synchronous, active-high.
REQ-005 The block SHALL have port l_stb_i, input, width 1: one-cycle strobe, new left sample valid.
REQ-006 The block SHALL have port l_data_i, input, width 24: signed left sample.
REQ-007 The block SHALL have port r_stb_i, input, width 1: one-cycle strobe, new right sample valid.
REQ-008 The block SHALL have port r_data_i, input, width 24: signed right sample.
REQ-009 The block SHALL have port mute_i, input, width 1: forces loaded words to zero.
REQ-010 The block SHALL have port sdo_o, output, width 4: serial data to DACs 0-3; bits 0 and 2 carry left, bits 1 and 3 carry right.
REQ-011 The block SHALL have port le_o, output, width 4: per-DAC latch enable, idle high.
REQ-012 The block SHALL have port busy_o, output, width 1: high while a load is in SHIFT or LATCH.
REQ-013 The block SHALL have port ovf_o, output, width 1: sticky overrun flag.

Function
REQ-014 The block SHALL hold each channel in a 24-bit holding register with a pending flag; a strobe writes the register and sets the flag at the next edge.
REQ-015 The block SHALL set ovf_o when a strobe arrives while that channel's flag is already set; the old sample is overwritten, and ovf_o stays set until reset.
REQ-016 The FSM SHALL have states IDLE, SHIFT and LATCH: IDLE goes to SHIFT when any flag is set; SHIFT goes to LATCH after BITS cycles; LATCH goes to IDLE after LATCH_LEN cycles.
REQ-017 On leaving IDLE, the FSM SHALL select a channel, load its word into the shifter and clear its flag.
REQ-018 If both flags are set on leaving IDLE, the FSM SHALL select the channel not served last (round-robin); after reset, the last-served channel is right, so left wins first.
REQ-019 A strobe for the selected channel in the load cycle SHALL keep its flag set with the new data, and SHALL NOT raise ovf_o; the shifter gets the old data.
REQ-020 If mute_i is high in the load cycle, the shifter SHALL load zero.
REQ-021 In SHIFT cycle k (1..BITS), sdo_o of the selected pair SHALL present word bit BITS-k, MSB first; the unselected pair's sdo_o is 0.
REQ-022 In LATCH, le_o of the selected pair SHALL be 0 and sdo_o SHALL be 0; le_o is 1 at all other times.
REQ-023 Latency: a strobe in cycle N to an idle block SHALL give SHIFT in N+2..N+BITS+1, LATCH in the following LATCH_LEN cycles, then IDLE.
REQ-024 busy_o SHALL equal (state != IDLE).

Reset
REQ-025 While rst_i is high at an edge, the block SHALL set state IDLE, flags 0, holding registers and shifter 0, sdo_o 0, le_o 4'b1111, busy_o 0 and ovf_o 0, and the last-served channel to right.
REQ-026 Reset mid-SHIFT or mid-LATCH SHALL abort the load without any LE low pulse after reset.

Configuration
REQ-027 With macro PCM56_ROUND_SAT_EN defined, the loaded word SHALL be the upper BITS bits of (sample + 2^(23-BITS)), saturated to 24-bit signed, so 0x7FFFFF stays 0x7FFF.
REQ-028 Without PCM56_ROUND_SAT_EN, the loaded word SHALL be the upper BITS bits of the sample (truncation).

Verification
REQ-029 The bench SHALL cover: l_stb_i with 0x123456 at cycle 10 -> sdo_o[0] and [2] serialise 0x1234 MSB first in cycles 12-27, le_o[0] and [2] low in cycles 28-29, busy_o low at 30.
REQ-030 The bench SHALL cover: l_stb_i and r_stb_i in the same cycle -> left load completes first, then the right load starts at the next IDLE exit; a second simultaneous pair is served right first.
REQ-031 The bench SHALL cover: two l_stb_i during one right load -> ovf_o=1, and only the second left value is shifted.
REQ-032 The bench SHALL cover: mute_i=1 at the load cycle with 0x7FFFFF -> all-zero word shifted, and LE still pulses.
REQ-033 The bench SHALL cover: rst_i asserted at SHIFT bit 5 -> next cycle le_o=4'b1111, sdo_o=0, busy_o=0, and no flags set.
REQ-034 The bench SHALL cover: with PCM56_ROUND_SAT_EN, 0x1234C0 -> 0x1235 and 0x7FFFFF -> 0x7FFF; without it, 0x1234C0 -> 0x1234.
